// File: rtl/pipe_mux_reg.sv
// N-channel, W-bit selector feeding a registered pipeline of STAGES stages.
// Carries a valid bit, honours stall/flush, and raises a sticky flag on
// out-of-range valid selects. All outputs come straight from flops.
module pipe_mux_reg #(
    parameter int unsigned    n         = 32,
    parameter int unsigned    CH        = 4,
    parameter int unsigned    STAGES    = 1,
    parameter logic [n-1:0]   FLUSH_VAL = '0,
    localparam int unsigned   SELW      = $clog2(CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*n-1:0]   In,
    input  logic [SELW-1:0]   Choose,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [n-1:0]      Out,
    output logic              out_valid,
    output logic              sel_err
);

    // Reject illegal configurations at elaboration time.
    if (STAGES < 1) begin : g_bad_stages
        $error("pipe_mux_reg: STAGES must be at least 1");
    end
    if (CH < 2) begin : g_bad_ch
        $error("pipe_mux_reg: CH must be at least 2");
    end

    logic [n-1:0] data_q  [STAGES];
    logic         valid_q [STAGES];
    logic         sel_err_q;

    logic [n-1:0] sel_data;
    logic         sel_valid;
    logic         sel_bad;

    // Stage-0 selection; selects past the last channel become bubbles.
    always_comb begin
        sel_data  = FLUSH_VAL;
        sel_valid = 1'b0;
        sel_bad   = 1'b1;
        for (int k = 0; k < int'(CH); k++) begin
            if (int'(Choose) == k) begin
                sel_data  = In[k*n +: n];
                sel_valid = in_valid;
                sel_bad   = 1'b0;
            end
        end
    end

    // Pipeline chain: flush beats stall, stall holds everything, else shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                data_q[i]  <= FLUSH_VAL;
                valid_q[i] <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                data_q[i]  <= FLUSH_VAL;
                valid_q[i] <= 1'b0;
            end
        end else if (!stall) begin
            data_q[0]  <= sel_data;
            valid_q[0] <= sel_valid;
            for (int i = 1; i < int'(STAGES); i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Sticky select-error flag, cleared only by reset or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else if (flush) begin
            sel_err_q <= 1'b0;
        end else if (!stall && sel_bad && in_valid) begin
            sel_err_q <= 1'b1;
        end
    end

    assign Out       = data_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Bench for pipe_mux_reg: two instances (CH=4/STAGES=2 and CH=3/STAGES=3)
// share clock and control, each tracked by a queue-based pipeline model.
module tb_pipe_mux_reg;

    localparam int unsigned SA = 2;
    localparam int unsigned SB = 3;
    localparam logic [31:0] FB = 32'hA5A5_0F0F;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  cha = '0;
    logic [1:0]  chb = '0;
    logic [31:0] ina [4];
    logic [31:0] inb [3];
    logic [127:0] in_a;
    logic [95:0]  in_b;

    logic [31:0] out_a, out_b;
    logic        ov_a, ov_b, err_a, err_b;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    assign in_a = {ina[3], ina[2], ina[1], ina[0]};
    assign in_b = {inb[2], inb[1], inb[0]};

    always #5 clk = ~clk;

    pipe_mux_reg #(.n(32), .CH(4), .STAGES(SA), .FLUSH_VAL(32'h0)) u_a (
        .clk(clk), .rst(rst), .In(in_a), .Choose(cha), .in_valid(in_valid),
        .stall(stall), .flush(flush), .Out(out_a), .out_valid(ov_a), .sel_err(err_a)
    );

    pipe_mux_reg #(.n(32), .CH(3), .STAGES(SB), .FLUSH_VAL(FB)) u_b (
        .clk(clk), .rst(rst), .In(in_b), .Choose(chb), .in_valid(in_valid),
        .stall(stall), .flush(flush), .Out(out_b), .out_valid(ov_b), .sel_err(err_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each pipeline is a queue, newest entry at the front.
    ent_t qa[$];
    ent_t qb[$];
    logic merr_a, merr_b;
    ent_t ea, eb;

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            qa = {};
            qb = {};
            repeat (SA) qa.push_back('{1'b0, 32'h0});
            repeat (SB) qb.push_back('{1'b0, FB});
            merr_a = 1'b0;
            merr_b = 1'b0;
        end else if (!stall) begin
            ea = '{in_valid, ina[cha]};
            if (chb < 2'd3) begin
                eb = '{in_valid, inb[chb]};
            end else begin
                eb = '{1'b0, FB};
                if (in_valid) merr_b = 1'b1;
            end
            qa.push_front(ea);
            void'(qa.pop_back());
            qb.push_front(eb);
            void'(qb.pop_back());
        end
    end

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_out",   {32'h0, out_a}, {32'h0, qa[SA-1].d});
            check("a_valid", {63'h0, ov_a},  {63'h0, qa[SA-1].v});
            check("a_err",   {63'h0, err_a}, {63'h0, merr_a});
            check("b_out",   {32'h0, out_b}, {32'h0, qb[SB-1].d});
            check("b_valid", {63'h0, ov_b},  {63'h0, qb[SB-1].v});
            check("b_err",   {63'h0, err_b}, {63'h0, merr_b});
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        ina[0] = 32'h1111_1111; ina[1] = 32'h2222_2222;
        ina[2] = 32'h3333_3333; ina[3] = 32'h4444_4444;
        inb[0] = 32'hB000_0000; inb[1] = 32'hB111_1111; inb[2] = 32'hB222_2222;

        // Reset state
        #1 rst = 1'b1;
        step();
        step();
        check("rst_out_a",   {32'h0, out_a}, 64'h0);
        check("rst_valid_a", {63'h0, ov_a},  64'h0);
        check("rst_out_b",   {32'h0, out_b}, {32'h0, FB});
        check("rst_err_b",   {63'h0, err_b}, 64'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Single entry, latency STAGES
        cha = 2'd2; in_valid = 1'b1;
        step();
        check("t1_c1_valid", {63'h0, ov_a}, 64'h0);
        check("t1_c1_out", {32'h0, out_a}, 64'h0);
        in_valid = 1'b0;
        step();
        check("t1_out",   {32'h0, out_a}, 64'h3333_3333);
        check("t1_valid", {63'h0, ov_a},  64'h1);

        // Back-to-back selects
        cha = 2'd0; in_valid = 1'b1;
        step();
        cha = 2'd1;
        step();
        check("t2_out0", {32'h0, out_a}, 64'h1111_1111);
        cha = 2'd3;
        step();
        check("t2_out1", {32'h0, out_a}, 64'h2222_2222);
        check("t2_v1",   {63'h0, ov_a},  64'h1);
        in_valid = 1'b0;
        step();
        check("t2_out2", {32'h0, out_a}, 64'h4444_4444);
        check("t2_v2",   {63'h0, ov_a},  64'h1);

        // Stall adds one cycle per stalled edge, no duplicates
        cha = 2'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; stall = 1'b1;
        step();
        check("t3_hold1", {32'h0, out_a}, 64'h4444_4444);
        check("t3_hv1",   {63'h0, ov_a},  64'h0);
        step();
        check("t3_hold2", {32'h0, out_a}, 64'h4444_4444);
        stall = 1'b0;
        step();
        check("t3_out", {32'h0, out_a}, 64'h2222_2222);
        check("t3_v",   {63'h0, ov_a},  64'h1);
        step();
        check("t3_norepeat", {63'h0, ov_a}, 64'h0);

        // Flush together with stall empties the pipe
        cha = 2'd0; in_valid = 1'b1;
        step();
        cha = 2'd1;
        step();
        in_valid = 1'b0; flush = 1'b1; stall = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        check("t4_out",   {32'h0, out_a}, 64'h0);
        check("t4_valid", {63'h0, ov_a},  64'h0);
        step();
        check("t4_gone1", {63'h0, ov_a}, 64'h0);
        step();
        check("t4_gone2", {63'h0, ov_a}, 64'h0);

        // Out-of-range select on the CH=3 instance
        chb = 2'd3; in_valid = 1'b1;
        step();
        check("t5_err_set", {63'h0, err_b}, 64'h1);
        chb = 2'd0; in_valid = 1'b0;
        step();
        step();
        check("t5_exit_v",   {63'h0, ov_b},  64'h0);
        check("t5_exit_out", {32'h0, out_b}, {32'h0, FB});
        check("t5_sticky",   {63'h0, err_b}, 64'h1);
        flush = 1'b1;
        step();
        check("t5_cleared", {63'h0, err_b}, 64'h0);
        chb = 2'd3; in_valid = 1'b1;
        step();
        check("t5_flush_wins", {63'h0, err_b}, 64'h0);
        flush = 1'b0; chb = 2'd0; in_valid = 1'b0;

        // Asynchronous reset mid-cycle
        chb = 2'd3; cha = 2'd2; in_valid = 1'b1;
        step();
        chb = 2'd0; in_valid = 1'b0;
        step();
        check("t6_pre_v",   {63'h0, ov_a},  64'h1);
        check("t6_pre_err", {63'h0, err_b}, 64'h1);
        #3 rst = 1'b1;
        #1;
        check("t6_out",   {32'h0, out_a}, 64'h0);
        check("t6_valid", {63'h0, ov_a},  64'h0);
        check("t6_err",   {63'h0, err_b}, 64'h0);
        step();
        rst = 1'b0;

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 4; k++) ina[k] = $urandom;
            for (int k = 0; k < 3; k++) inb[k] = $urandom;
            cha      = 2'($urandom_range(0, 3));
            chb      = 2'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 29) == 0);
            step();
        end
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_mux_reg.md
Name: pipe_mux_reg

Overview:
Parametrised N-channel, W-bit selector with an integrated pipeline register chain of configurable depth. It replaces the bare 2-to-1 combinational selectors at pipeline-stage boundaries, such as the ALU operand, forwarding and writeback-source selects. It carries a valid bit and honours the pipeline's stall and flush controls. It also flags out-of-range selects.

Parameters:
n, 32, data width in bits.
CH, 4, number of input channels (>= 2).
STAGES, 1, register stages between select and output (>= 1; 0 is illegal and must fail elaboration).
FLUSH_VAL, 0, n-bit value loaded into data registers on reset and flush.
SELW, $clog2(CH), select width (derived; not overridden).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
In  input  CH*n  flattened channels; channel k occupies In[k*n +: n].
Choose  input  SELW  binary channel select.
in_valid  input  1  the selected input is a real instruction/operand.
stall  input  1  hold all stages.
flush  input  1  kill all in-flight entries.
Out  output  n  data from the last stage (registered).
out_valid  output  1  valid bit from the last stage (registered).
sel_err  output  1  sticky out-of-range-select flag.

Behaviour:
- Reset is asynchronous and active-high (rst); clock is clk; single clock domain.
- Reset: every stage's data = FLUSH_VAL, every valid = 0, sel_err = 0. Out = FLUSH_VAL, out_valid = 0 while rst is high and until the first non-reset edge.
- Stage 0 input selection (combinational):
  - Choose < CH: data = In[Choose*n +: n], valid = in_valid.
  - Choose >= CH (only reachable when CH is not a power of 2): data = FLUSH_VAL, valid = 0.
- Priority per edge: rst > flush > stall > advance.
- flush = 1: all stages load data = FLUSH_VAL, valid = 0. This applies even if stall = 1. Stage 0 does not capture In on that edge.
- stall = 1 (no flush): every stage holds its data and valid. sel_err does not update.
- Advance (no stall, no flush):
  - Stage 0 captures the selection.
  - Stage i captures stage i-1.
  - Out and out_valid are taken from stage STAGES-1.
- Latency: a value presented on cycle t with no stall appears on Out on cycle t+STAGES. Each stalled cycle adds exactly one cycle; nothing is dropped or duplicated.
- Throughput: one entry per non-stalled cycle.
- sel_err:
  - Set on an advancing edge when Choose >= CH and in_valid = 1.
  - Stays set until rst or flush.
  - If flush and an erroneous select occur on the same edge, flush wins and sel_err = 0.
- in_valid = 0 entries propagate as bubbles: their data is still captured, and out_valid = 0 when they reach the output.
- Out is never driven combinationally from In: no combinational path from In, Choose, stall or flush to any output.
- Reset asserted mid-stream discards all in-flight entries immediately (asynchronous). Deassertion resumes with empty stages.

Test Plan:
1. Reset, then n=32, CH=4, STAGES=2: In ch0..ch3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; Choose = 2, in_valid = 1 at cycle 0 -> Out = 0x33333333 and out_valid = 1 at cycle 2; Out = 0 and out_valid = 0 at cycles 0–1.
2. Back-to-back Choose = 0, 1, 3 on cycles 0–2, STAGES=2 -> Out sequence 0x11111111, 0x22222222, 0x44444444 on cycles 2–4; out_valid = 1 on each.
3. Choose = 1 at cycle 0, stall high on cycles 1–2 -> Out = 0x22222222 first appears at cycle 4 and is not repeated; Out is held constant during the stall.
4. Two valid entries in flight, then flush = 1 together with stall = 1 -> next cycle all stages empty: out_valid = 0, Out = FLUSH_VAL (0); the entries never appear.
5. CH=3: Choose = 3, in_valid = 1 on an advancing edge -> sel_err = 1 and stays 1; that entry exits with out_valid = 0 and Out = 0. A later flush clears sel_err to 0.
6. rst pulsed asynchronously mid-cycle with a valid entry in stage 1 -> Out = 0, out_valid = 0 and sel_err = 0 immediately, without waiting for a clk edge.
